// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button 2-flop synchronizer and counter debouncer.
// Emits c/l/r as debounced levels and u/d as one-cycle pulses on debounced presses.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic       btnc,
  output logic       btnl,
  output logic       btnr,
  output logic       btnu_pulse,
  output logic       btnd_pulse
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [4:0]           r_s1, r_s2, r_stable;
  logic [CNT_WIDTH-1:0] r_cnt [5];
  logic                 r_up_pulse, r_dn_pulse;
  logic [4:0]           w_flip, w_agree;
  always_comb begin
    w_flip  = '0;
    w_agree = r_s2 ~^ r_stable;
    for (int i = 0; i < 5; i++) w_flip[i] = !w_agree[i] && r_cnt[i] == LAST;
  end
  // A pulse is raised only on the 0->1 flip, so release and long holds stay silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_up_pulse <= 1'b0;
      r_dn_pulse <= 1'b0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_s1       <= btn_raw;
      r_s2       <= r_s1;
      r_stable   <= r_stable ^ w_flip;
      r_up_pulse <= w_flip[2] & r_s2[2];
      r_dn_pulse <= w_flip[4] & r_s2[4];
      for (int i = 0; i < 5; i++) r_cnt[i] <= (w_agree[i] || w_flip[i]) ? '0 : r_cnt[i] + CNT_WIDTH'(1);
    end
  end
  assign btnc       = r_stable[0];
  assign btnl       = r_stable[1];
  assign btnr       = r_stable[3];
  assign btnu_pulse = r_up_pulse;
  assign btnd_pulse = r_dn_pulse;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: random and directed stimulus against a windowed reference model,
// with a per-cycle scoreboard for a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance.
module tb_btn_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = '0;
  logic       c4, l4, r4, u4, d4, c1, l1, r1, u1, d1;
  logic [4:0] o4, o1;
  logic [4:0] exp4[$], exp1[$];
  logic [4:0] q4[$], q1[$];
  logic [4:0] st4, st1;
  int         total = 0, bad = 0;
  int         nu4 = 0, nd4 = 0, nd1 = 0;
  btn_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut4 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btnc(c4), .btnl(l4), .btnr(r4), .btnu_pulse(u4), .btnd_pulse(d4)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btnc(c1), .btnl(l1), .btnr(r1), .btnu_pulse(u1), .btnd_pulse(d1)
  );
  assign o4 = {d4, u4, r4, l4, c4};
  assign o1 = {d1, u1, r1, l1, c1};
  always #5 clk = ~clk;
  // A bit flips when the last d synchronised samples (raw taken 2..d+1 edges ago) all oppose it.
  function automatic logic [4:0] flips(input logic [4:0] h[$], input logic [4:0] st, input int d);
    logic [4:0] m;
    m = '1;
    for (int j = 2; j <= d + 1; j++) m = m & (h[h.size() - j] ^ st);
    return m;
  endfunction
  initial begin
    logic [4:0] f;
    forever begin
      @(posedge clk);
      if (rst) begin
        st4 = '0;
        st1 = '0;
        q4.delete();
        q1.delete();
        repeat (6) q4.push_back('0);
        repeat (3) q1.push_back('0);
        exp4.push_back('0);
        exp1.push_back('0);
      end else begin
        f = flips(q4, st4, 4);
        st4 = st4 ^ f;
        exp4.push_back({f[4] & st4[4], f[2] & st4[2], st4[3], st4[1], st4[0]});
        q4.push_back(btn_raw);
        void'(q4.pop_front());
        f = flips(q1, st1, 1);
        st1 = st1 ^ f;
        exp1.push_back({f[4] & st1[4], f[2] & st1[2], st1[3], st1[1], st1[0]});
        q1.push_back(btn_raw);
        void'(q1.pop_front());
      end
    end
  end
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      total++;
      if (exp4.size() == 0) begin bad++; $display("FAIL out4 no expected entry t=%0t", $time); end
      else begin
        e = exp4.pop_front();
        if (o4 !== e) begin bad++; $display("FAIL out4 got=%b want=%b t=%0t", o4, e, $time); end
      end
      total++;
      if (exp1.size() == 0) begin bad++; $display("FAIL out1 no expected entry t=%0t", $time); end
      else begin
        e = exp1.pop_front();
        if (o1 !== e) begin bad++; $display("FAIL out1 got=%b want=%b t=%0t", o1, e, $time); end
      end
      if (u4) nu4++;
      if (d4) nd4++;
      if (d1) nd1++;
    end
  end
  task automatic drive(input logic [4:0] v, input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
      btn_raw = v;
    end
  endtask
  task automatic expect_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin bad++; $display("FAIL %s got=%0d want=%0d", name, got, want); end
  endtask
  initial begin
    int u0, d0, k0;
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    drive(5'h1F, 20);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    expect_int("async_rst4", int'(o4), 0);
    expect_int("async_rst1", int'(o1), 0);
    drive(5'h1F, 3);
    u0 = nu4; d0 = nd4;
    #0 rst = 1'b0;
    drive(5'h1F, 20);
    expect_int("rst_rel_up", nu4 - u0, 1);
    expect_int("rst_rel_dn", nd4 - d0, 1);
    drive(5'h00, 20);
    d0 = nd4;
    drive(5'h10, 30);
    drive(5'h00, 20);
    expect_int("clean_press_dn", nd4 - d0, 1);
    for (int i = 0; i < 5; i++) begin drive(5'h02, 2); drive(5'h00, 2); end
    drive(5'h02, 20);
    drive(5'h00, 20);
    drive(5'h01, 12);
    drive(5'h00, 3);
    drive(5'h01, 12);
    drive(5'h00, 4);
    drive(5'h00, 10);
    u0 = nu4; d0 = nd4;
    drive(5'h14, 20);
    drive(5'h00, 20);
    expect_int("simul_up", nu4 - u0, 1);
    expect_int("simul_dn", nd4 - d0, 1);
    d0 = nd4; k0 = nd1;
    drive(5'h10, 100);
    drive(5'h00, 10);
    drive(5'h10, 20);
    drive(5'h00, 20);
    expect_int("repress_dn4", nd4 - d0, 2);
    expect_int("repress_dn1", nd1 - k0, 2);
    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      drive(r[4:0], $urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) begin
        @(posedge clk);
        #4 rst = 1'b1;
        drive(r[9:5], 2);
        #0 rst = 1'b0;
      end
    end
    drive(5'h00, 10);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
